// File: rtl/fetch_pc_predictor.sv
// IF-stage fetch PC register with a direct-mapped 2-bit BHT + BTB predicting the next fetch PC.
// Redirect takes effect on the next edge; table writes become visible to lookups one cycle later.
module fetch_pc_predictor #(
    parameter int          INDEX_W  = 6,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_PC,
    input  logic        comp_o,
    input  logic [31:0] PC_jump_EX,
    input  logic        PCSel_EX,
    input  logic [6:0]  op_ex,
    input  logic [31:0] pc_EX,
    output logic [31:0] pc_IF,
    output logic        pred_taken_IF,
    output logic [31:0] pred_next_IF,
    output logic [31:0] branch_cnt,
    output logic [31:0] mispred_cnt
);

    localparam int ENTRIES = 1 << INDEX_W;
    localparam int TAG_W   = 32 - INDEX_W - 2;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [31:0]        tgt_q [ENTRIES];
    logic [1:0]         ctr_q [ENTRIES];

    logic [31:0] pc_q, pc_d;
    logic [31:0] branch_cnt_q, branch_cnt_d;
    logic [31:0] mispred_cnt_q, mispred_cnt_d;

    logic [INDEX_W-1:0] if_idx;
    logic [TAG_W-1:0]   if_tag;
    logic               if_hit;
    logic [31:0]        pc_plus4;

    logic [INDEX_W-1:0] ex_idx;
    logic [TAG_W-1:0]   ex_tag;
    logic               ex_hit;
    logic               train;

    logic               wr_en;
    logic [TAG_W-1:0]   wr_tag;
    logic [31:0]        wr_tgt;
    logic [1:0]         wr_ctr;

    logic unused_bits;
    assign unused_bits = ^{op_ex[3:0], pc_EX[1:0]};

    // Lookup on the registered fetch PC
    assign if_idx        = pc_q[INDEX_W+1:2];
    assign if_tag        = pc_q[31:INDEX_W+2];
    assign if_hit        = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign pc_plus4      = pc_q + 32'd4;
    assign pred_taken_IF = if_hit && ctr_q[if_idx][1];
    assign pred_next_IF  = pred_taken_IF ? tgt_q[if_idx] : pc_plus4;

    assign pc_IF       = pc_q;
    assign branch_cnt  = branch_cnt_q;
    assign mispred_cnt = mispred_cnt_q;

    always_comb begin
        pc_d = pc_q;
        if (comp_o) begin
            pc_d = PC_jump_EX;
        end else if (!stall_PC) begin
            pc_d = pred_next_IF;
        end
    end

    // Training: JAL/JALR/branches share op_ex[6:4] == 3'b110; bubbles carry op_ex = 0
    assign train  = (op_ex[6:4] == 3'b110);
    assign ex_idx = pc_EX[INDEX_W+1:2];
    assign ex_tag = pc_EX[31:INDEX_W+2];
    assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

    always_comb begin
        wr_en  = 1'b0;
        wr_tag = ex_tag;
        wr_tgt = tgt_q[ex_idx];
        wr_ctr = ctr_q[ex_idx];
        if (train) begin
            if (ex_hit) begin
                wr_en = 1'b1;
                if (PCSel_EX) begin
                    wr_tgt = PC_jump_EX;
                    wr_ctr = (ctr_q[ex_idx] == 2'b11) ? 2'b11 : ctr_q[ex_idx] + 2'b01;
                end else begin
                    wr_ctr = (ctr_q[ex_idx] == 2'b00) ? 2'b00 : ctr_q[ex_idx] - 2'b01;
                end
            end else if (PCSel_EX) begin
                wr_en  = 1'b1;
                wr_tgt = PC_jump_EX;
                wr_ctr = 2'b10;
            end
        end
    end

    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (train && (branch_cnt_q != 32'hFFFF_FFFF)) begin
            branch_cnt_d = branch_cnt_q + 32'd1;
        end
        if (comp_o && (mispred_cnt_q != 32'hFFFF_FFFF)) begin
            mispred_cnt_d = mispred_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q          <= RESET_PC;
            branch_cnt_q  <= 32'd0;
            mispred_cnt_q <= 32'd0;
        end else begin
            pc_q          <= pc_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    // Tag/target are also cleared so nothing X can reach the outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
                ctr_q[i] <= 2'b01;
            end
        end else if (wr_en) begin
            valid_q[ex_idx] <= 1'b1;
            tag_q[ex_idx]   <= wr_tag;
            tgt_q[ex_idx]   <= wr_tgt;
            ctr_q[ex_idx]   <= wr_ctr;
        end
    end

endmodule

// File: tb/tb_fetch_pc_predictor.sv
// Directed plus randomized bench for fetch_pc_predictor against an array-based reference model.
module tb_fetch_pc_predictor;

    localparam int          IW      = 6;
    localparam int          NENT    = 1 << IW;
    localparam logic [31:0] RST_PC  = 32'h100;
    localparam logic [6:0]  OP_BR   = 7'b1100011;
    localparam logic [6:0]  OP_JAL  = 7'b1101111;
    localparam logic [6:0]  OP_JALR = 7'b1100111;
    localparam logic [6:0]  OP_ALU  = 7'b0110011;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        stall_PC, comp_o, PCSel_EX;
    logic [31:0] PC_jump_EX, pc_EX;
    logic [6:0]  op_ex;
    logic [31:0] pc_IF, pred_next_IF, branch_cnt, mispred_cnt;
    logic        pred_taken_IF;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit          m_valid [NENT];
    bit [31:0]   m_pcof  [NENT];
    bit [31:0]   m_tgt   [NENT];
    int          m_ctr   [NENT];
    bit [31:0]   m_pc, m_bcnt, m_mcnt;

    fetch_pc_predictor #(.INDEX_W(IW), .RESET_PC(RST_PC)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .stall_PC(stall_PC), .comp_o(comp_o),
        .PC_jump_EX(PC_jump_EX), .PCSel_EX(PCSel_EX), .op_ex(op_ex), .pc_EX(pc_EX),
        .pc_IF(pc_IF), .pred_taken_IF(pred_taken_IF), .pred_next_IF(pred_next_IF),
        .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int slot(input bit [31:0] pc);
        return int'((pc >> 2) % NENT);
    endfunction

    // An entry matches when it was stored for an address with the same upper bits
    function automatic bit m_hit(input bit [31:0] pc);
        return m_valid[slot(pc)] && ((m_pcof[slot(pc)] >> (IW + 2)) == (pc >> (IW + 2)));
    endfunction

    function automatic bit m_taken(input bit [31:0] pc);
        return m_hit(pc) && (m_ctr[slot(pc)] >= 2);
    endfunction

    function automatic bit [31:0] m_next(input bit [31:0] pc);
        return m_taken(pc) ? m_tgt[slot(pc)] : pc + 32'd4;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NENT; i++) begin
            m_valid[i] = 0;
            m_ctr[i]   = 1;
        end
        m_pc   = RST_PC;
        m_bcnt = 0;
        m_mcnt = 0;
    endtask

    task automatic model_step();
        bit [31:0] npc;
        int        s;
        bit        is_cf;
        is_cf = (op_ex == OP_BR) || (op_ex == OP_JAL) || (op_ex == OP_JALR);
        if (comp_o)         npc = PC_jump_EX;
        else if (stall_PC)  npc = m_pc;
        else                npc = m_next(m_pc);
        if (is_cf) begin
            s = slot(pc_EX);
            if (m_hit(pc_EX)) begin
                if (PCSel_EX) begin
                    m_ctr[s] = (m_ctr[s] < 3) ? m_ctr[s] + 1 : 3;
                    m_tgt[s] = PC_jump_EX;
                end else begin
                    m_ctr[s] = (m_ctr[s] > 0) ? m_ctr[s] - 1 : 0;
                end
            end else if (PCSel_EX) begin
                m_valid[s] = 1;
                m_pcof[s]  = pc_EX;
                m_tgt[s]   = PC_jump_EX;
                m_ctr[s]   = 2;
            end
            if (m_bcnt != 32'hFFFF_FFFF) m_bcnt++;
        end
        if (comp_o && m_mcnt != 32'hFFFF_FFFF) m_mcnt++;
        m_pc = npc;
    endtask

    task automatic compare_model();
        chk("pc_IF", pc_IF, m_pc);
        chk("pred_taken", {31'b0, pred_taken_IF}, {31'b0, m_taken(m_pc)});
        chk("pred_next", pred_next_IF, m_next(m_pc));
        chk("branch_cnt", branch_cnt, m_bcnt);
        chk("mispred_cnt", mispred_cnt, m_mcnt);
    endtask

    task automatic drive(input bit st, input bit cp, input bit [31:0] jmp,
                         input bit sel, input bit [6:0] op, input bit [31:0] pex);
        stall_PC   = st;
        comp_o     = cp;
        PC_jump_EX = jmp;
        PCSel_EX   = sel;
        op_ex      = op;
        pc_EX      = pex;
    endtask

    task automatic tick();
        @(posedge clk_i);
        model_step();
        @(negedge clk_i);
        compare_model();
    endtask

    function automatic bit [31:0] rand_pc();
        bit [31:0] p;
        if ($urandom_range(0, 31) == 0) return 32'hFFFF_FFFC;
        p = ($urandom_range(0, 3) << 12) + ($urandom_range(0, 15) << 2) + 32'h200;
        return p;
    endfunction

    initial begin
        bit [31:0] pex, jmp;
        bit        sel;
        bit [6:0]  op;
        rst_i = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        model_reset();
        @(negedge clk_i);
        compare_model();
        chk("rst_pc", pc_IF, 32'h100);
        chk("rst_next", pred_next_IF, 32'h104);
        rst_i = 1'b0;

        // Sequential fetch after reset
        tick(); chk("seq1", pc_IF, 32'h104);
        tick(); chk("seq2", pc_IF, 32'h108);
        chk("seq_ntaken", {31'b0, pred_taken_IF}, 32'h0);

        // Allocate on taken miss, then redirect fetch onto that branch
        drive(0, 0, 32'h300, 1, OP_BR, 32'h200); tick();
        drive(0, 1, 32'h200, 0, 7'd0, 0);        tick();
        chk("alloc_taken", {31'b0, pred_taken_IF}, 32'h1);
        chk("alloc_next", pred_next_IF, 32'h300);

        // Hold at 0x200 while training: 10 -> 01 -> 00, stays 00, then -> 01
        drive(1, 0, 32'h204, 0, OP_BR, 32'h200); tick();
        chk("nt1", {31'b0, pred_taken_IF}, 32'h0);
        tick();
        chk("nt2_next", pred_next_IF, 32'h204);
        tick();
        drive(1, 0, 32'h300, 1, OP_BR, 32'h200); tick();
        chk("sat_lo", {31'b0, pred_taken_IF}, 32'h0);
        tick(); tick(); tick(); tick();
        drive(1, 0, 32'h204, 0, OP_BR, 32'h200); tick();
        chk("sat_hi_1nt", {31'b0, pred_taken_IF}, 32'h1);
        tick();
        chk("sat_hi_2nt", {31'b0, pred_taken_IF}, 32'h0);

        // Redirect overrides stall
        drive(1, 1, 32'h480, 0, 7'd0, 0); tick();
        chk("redir_pc", pc_IF, 32'h480);

        // Same-cycle write/lookup at the fetch index: old value this cycle, new next
        drive(1, 0, 32'h600, 1, OP_JAL, 32'h480);
        #1 chk("rw_old", {31'b0, pred_taken_IF}, 32'h0);
        tick();
        chk("rw_new", {31'b0, pred_taken_IF}, 32'h1);
        chk("rw_next", pred_next_IF, 32'h600);

        // Reset mid-stream drops the pending update and invalidates the table
        drive(0, 1, 32'h700, 1, OP_BR, 32'h480);
        #2 rst_i = 1'b1;
        model_reset();
        #1 chk("mid_rst_pc", pc_IF, 32'h100);
        chk("mid_rst_bcnt", branch_cnt, 32'h0);
        compare_model();
        rst_i = 1'b0;
        drive(1, 1, 32'h480, 0, 7'd0, 0); tick();
        chk("mid_rst_inval", {31'b0, pred_taken_IF}, 32'h0);

        // Wrap of pc+4
        drive(0, 1, 32'hFFFF_FFFC, 0, 7'd0, 0); tick();
        drive(0, 0, 0, 0, 7'd0, 0); tick();
        chk("wrap", pc_IF, 32'h0);

        // Randomized phase
        for (int n = 0; n < 3000; n++) begin
            pex = ($urandom_range(0, 1) == 0) ? m_pc : rand_pc();
            sel = $urandom_range(0, 1);
            jmp = sel ? rand_pc() : pex + 32'd4;
            case ($urandom_range(0, 5))
                0: op = OP_JAL;
                1: op = OP_JALR;
                2: op = 7'd0;
                3: op = OP_ALU;
                default: op = OP_BR;
            endcase
            drive($urandom_range(0, 6) == 0, $urandom_range(0, 4) == 0, jmp, sel, op, pex);
            if ($urandom_range(0, 199) == 0) begin
                #2 rst_i = 1'b1;
                model_reset();
                #1 compare_model();
                rst_i = 1'b0;
            end else begin
                tick();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_pc_predictor.md
Name: fetch_pc_predictor

Overview:
IF-stage PC generator with a direct-mapped two-bit branch history table (BHT) and branch target buffer (BTB). It drives the fetch PC and predicts the next PC. It consumes the EX-stage resolution signals produced by the hazard detection unit: comp_o, PC_jump_EX and stall_PC. It redirects fetch on a mispredict and trains the predictor with every resolved control-flow instruction.

Parameters:
INDEX_W, 6, table index width; entries = 2**INDEX_W (index = pc[INDEX_W+1:2]).
RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
clk_i  input  1  clock, rising edge.
rst_i  input  1  asynchronous, active-high reset.
stall_PC  input  1  hold the PC (load-use or structural stall).
comp_o  input  1  EX mispredict or redirect request from the hazard unit.
PC_jump_EX  input  32  resolved next PC of the EX instruction (target if taken, pc_EX+4 if not).
PCSel_EX  input  1  resolved branch outcome of the EX instruction (1 = taken).
op_ex  input  7  EX opcode.
pc_EX  input  32  EX instruction PC.
pc_IF  output  32  current fetch PC (registered).
pred_taken_IF  output  1  prediction for pc_IF.
pred_next_IF  output  32  predicted next fetch PC.
branch_cnt  output  32  resolved control-flow instruction count.
mispred_cnt  output  32  mispredict count.

Behaviour:
- Entry storage per index: valid (1), tag (pc[31:INDEX_W+2]), target (32), ctr (2).
- Reset (async, immediate):
  - pc_IF = RESET_PC.
  - All valid = 0, all ctr = 2'b01.
  - branch_cnt = 0, mispred_cnt = 0.
  - Outputs follow combinationally: pred_taken_IF = 0, pred_next_IF = RESET_PC+4.
- Lookup (combinational, on pc_IF):
  - hit = valid && tag match.
  - pred_taken_IF = hit && ctr[1].
  - pred_next_IF = pred_taken_IF ? target : pc_IF+4.
- PC register update, rising edge, in priority order:
  1. comp_o = 1: pc_IF <= PC_jump_EX. Overrides stall_PC.
  2. stall_PC = 1: hold.
  3. Otherwise: pc_IF <= pred_next_IF.
- Redirect latency: 1 cycle; the instruction after comp_o is fetched from PC_jump_EX.
- Training:
  - Occurs on every edge where op_ex[6:4] == 3'b110 (JAL, JALR, branches). Independent of stall_PC.
  - Flushed bubbles carry op_ex = 0 and never train.
  - Index and tag are taken from pc_EX.
- Hit, taken: ctr saturating increment (max 2'b11); target <= PC_jump_EX.
- Hit, not taken: ctr saturating decrement (min 2'b00); target unchanged.
- Miss, taken: allocate (replace) with valid=1, tag, target=PC_jump_EX, ctr=2'b10.
- Miss, not taken: no change.
- Read/write same index in same cycle: the lookup returns the pre-update value; no bypass. The write is visible from the next cycle.
- Counters:
  - branch_cnt increments on every training edge.
  - mispred_cnt increments on every edge with comp_o = 1.
  - Both saturate at 32'hFFFF_FFFF.
- Arithmetic: pc+4 is modulo 2**32 (32'hFFFF_FFFC + 4 = 0).
- No X on outputs after reset; tables are not cleared except by reset.
- Reset asserted mid-operation: state clears immediately; a pending update is lost.

Test Plan:
1. Reset with RESET_PC=32'h100, stall_PC=0, no branches -> pc_IF 0x100, 0x104, 0x108 on successive edges; pred_taken_IF=0.
2. Branch at pc_EX=0x200, PCSel_EX=1, PC_jump_EX=0x300, op_ex=7'b1100011 (miss) -> entry allocated with ctr=10. Next fetch of 0x200 -> pred_taken_IF=1, pred_next_IF=0x300.
3. Same branch resolved not-taken twice -> ctr 10 -> 01 -> 00. Fetch of 0x200 -> pred_next_IF=0x204. A third not-taken leaves ctr at 00.
4. Four taken resolutions starting from allocation -> ctr stays saturated at 11. One not-taken -> 10, still predicts taken.
5. comp_o=1 with PC_jump_EX=0x480 and stall_PC=1 in the same cycle -> next pc_IF=0x480; mispred_cnt +1.
6. Update to index k and lookup of pc_IF mapping to index k in the same cycle -> pred_taken_IF reflects the old entry that cycle and the new entry the following cycle. Then assert rst_i mid-stream -> pc_IF=RESET_PC at once and the entry is invalid.
